alu_issue_seq: RTL and testbench
================================

Name: alu_issue_seq

Overview:
- Command sequencer directly upstream of the 32-bit combinational ALU (ports op1/op2/alu_sel -> alu_out/zero/carry/overflow).
- Accepts register-based ALU commands over a valid/ready handshake and reads operands from a local register file.
- Drives registered operands into the ALU, captures the result and flags, writes the result back, and returns a response over a second valid/ready handshake.
- It is the stimulus/writeback shell that turns the ALU into a usable execute unit.

Parameters:
- NREGS, 16, number of 32-bit registers. Must be a power of two, 2..16. r0 is hardwired to zero.
- AW, 4, register address width. Must equal log2(NREGS).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_sel  input  4  ALU operation code, passed to the ALU unchanged.
- cmd_rd  input  AW  destination register.
- cmd_rs1  input  AW  source register for op1.
- cmd_rs2  input  AW  source register for op2 when cmd_use_imm=0.
- cmd_imm  input  32  immediate for op2 when cmd_use_imm=1.
- cmd_use_imm  input  1  select the immediate for op2.
- alu_op1  output  32  registered operand 1 to the ALU.
- alu_op2  output  32  registered operand 2 to the ALU.
- alu_sel  output  4  registered operation code to the ALU.
- alu_out  input  32  ALU result.
- alu_zero  input  1  ALU zero flag.
- alu_carry  input  1  ALU carry flag.
- alu_overflow  input  1  ALU overflow flag.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_data  output  32  captured result.
- rsp_flags  output  3  captured flags as {overflow, carry, zero}.
- rsp_err  output  1  illegal opcode.
- dbg_raddr  input  AW  debug read address.
- dbg_rdata  output  32  combinational register read; reads 0 for r0.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - All registers r1..rN-1 = 0.
  - alu_op1 = alu_op2 = 0; alu_sel = 4'b0000.
  - rsp_valid = 0; rsp_data = 0; rsp_flags = 0; rsp_err = 0.
  - cmd_ready = 0 while in reset, 1 in the first cycle after release.
- Legal opcodes: 0000 add, 0001 sub, 0100 and, 0101 or, 0110 xor, 1000 sll, 1001 srl, 1010 sra, 1100 sltu, 1101 eq. All other codes are illegal.
- FSM: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid && cmd_ready, at edge N:
    - alu_op1 <= R[rs1].
    - alu_op2 <= cmd_use_imm ? cmd_imm : R[rs2].
    - alu_sel <= cmd_sel.
    - Latch rd and the illegal bit; go to EXEC.
  - Register reads return 0 for index 0.
- EXEC:
  - cmd_ready=0. ALU inputs are stable for one full cycle.
  - At edge N+1:
    - rsp_data <= alu_out; rsp_flags <= {alu_overflow, alu_carry, alu_zero}.
    - If illegal: rsp_data <= 0, rsp_flags <= 0, rsp_err <= 1, no writeback.
    - Else: rsp_err <= 0 and R[rd] <= alu_out unless rd==0.
  - Go to RESP with rsp_valid <= 1.
- RESP:
  - cmd_ready=0.
  - rsp_valid, rsp_data, rsp_flags and rsp_err stay stable until rsp_ready.
  - On rsp_valid && rsp_ready: rsp_valid <= 0 and go to IDLE.
- Latency: response visible in the cycle after edge N+1 (2 edges after acceptance). Maximum throughput is 1 command per 3 cycles with rsp_ready tied high.
- Writeback precedes the response, so a dependent command issued after the response sees the new value. No hazard logic is required.
- alu_op1, alu_op2 and alu_sel hold their last values outside EXEC (no toggling).
- Reset mid-operation: the in-flight command is dropped, no writeback occurs, and all state returns to reset values immediately.
- dbg_rdata reflects a write on the cycle after the writeback edge.
- cmd_valid in EXEC or RESP is ignored; the command is not accepted until cmd_ready=1.

Optional Feature:
- Macro: ALU_STICKY_FLAGS_EN.
- Defined:
  - Adds ports sticky_clr (input, 1) and sticky_flags (output, 2, {overflow, carry}).
  - sticky_flags ORs in the captured overflow/carry at every legal EXEC capture.
  - sticky_clr=1 clears it synchronously. Clear wins over a set in the same cycle.
  - Reset value is 0.
- Undefined: both ports and all related logic are absent. Remaining behaviour is identical.

Test Plan:
- Reset, then write r1=0x10 (add r1=r0+imm 0x10), then add r2=r1+imm 0x20 -> rsp_data=0x30, flags=000, dbg_rdata(r2)=0x30, rsp_valid 2 edges after acceptance.
- Load r3=0x7FFFFFFF via imm, then add r4=r3+imm 1 -> rsp_data=0x80000000, rsp_flags overflow=1; with ALU_STICKY_FLAGS_EN, sticky_flags[1]=1 until sticky_clr.
- r5=0x80000000, then sra r6=r5 by imm 1 -> 0xC0000000; sub r7=r1-r1 -> rsp_data=0, zero=1.
- cmd_sel=4'b0011 with rd=8 -> rsp_err=1, rsp_data=0, r8 unchanged (0). A following legal command gives rsp_err=0.
- Hold rsp_ready=0 for 5 cycles with cmd_valid=1 asserted -> rsp_* stable, cmd_ready=0, and the second command is accepted only after the handshake. Write to rd=0 -> dbg_rdata(r0)=0.
- Assert rst_n=0 during EXEC of add r9=imm 0x55 -> r9=0, rsp_valid=0, and cmd_ready=1 the cycle after release.

Source files
------------

// File: rtl/alu_issue_seq.sv
// alu_issue_seq: command sequencer and writeback shell around a 32-bit
// combinational ALU. Commands read operands from a local register file
// (r0 hardwired to zero), the operands are registered into the ALU for one
// full cycle, and the result and flags are captured, written back and
// returned as a response.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// A producer holds valid and its payload stable until that edge; ready may
// depend on state but never on the valid of the same channel. cmd_ready is
// high only in IDLE (and low while rst_n is asserted); rsp_valid is high
// only in RESP, with rsp_* held stable until rsp_ready.
//
// Optional build macro: ALU_STICKY_FLAGS_EN adds sticky_clr / sticky_flags,
// an accumulating {overflow, carry} record of legal captures.
module alu_issue_seq #(
    parameter int NREGS = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [3:0]    cmd_sel,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_rs1,
    input  logic [AW-1:0] cmd_rs2,
    input  logic [31:0]   cmd_imm,
    input  logic          cmd_use_imm,
    output logic [31:0]   alu_op1,
    output logic [31:0]   alu_op2,
    output logic [3:0]    alu_sel,
    input  logic [31:0]   alu_out,
    input  logic          alu_zero,
    input  logic          alu_carry,
    input  logic          alu_overflow,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_data,
    output logic [2:0]    rsp_flags,
    output logic          rsp_err,
`ifdef ALU_STICKY_FLAGS_EN
    input  logic          sticky_clr,
    output logic [1:0]    sticky_flags,
`endif
    output logic [1:0]    dbg_state,
    input  logic [AW-1:0] dbg_raddr,
    output logic [31:0]   dbg_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [31:0]   regs [NREGS];
    logic [AW-1:0] rd_q;
    logic          ill_q;
    logic          sel_illegal;
    logic          accept;
    logic          wb_en;
    logic [31:0]   rs1_val;
    logic [31:0]   rs2_val;

    assign dbg_state = state_q;

    // Register reads: index 0 always reads as zero.
    assign rs1_val   = (cmd_rs1 == '0) ? 32'd0 : regs[cmd_rs1];
    assign rs2_val   = (cmd_rs2 == '0) ? 32'd0 : regs[cmd_rs2];
    assign dbg_rdata = (dbg_raddr == '0) ? 32'd0 : regs[dbg_raddr];

    assign accept = cmd_valid && cmd_ready;
    assign wb_en  = (state_q == EXEC) && !ill_q && (rd_q != '0);

    // Opcode legality decode; anything not in the list is flagged illegal.
    always_comb begin
        sel_illegal = 1'b1;
        case (cmd_sel)
            4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b0110,
            4'b1000, 4'b1001, 4'b1010, 4'b1100, 4'b1101: sel_illegal = 1'b0;
            default:                                     sel_illegal = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and cmd_ready; cmd_ready is forced low while in reset.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = rst_n;
                if (cmd_valid && rst_n) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand issue on acceptance, result/flag capture in EXEC, response release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op1   <= 32'd0;
            alu_op2   <= 32'd0;
            alu_sel   <= 4'b0000;
            rd_q      <= '0;
            ill_q     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'd0;
            rsp_flags <= 3'b000;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                alu_op1 <= rs1_val;
                alu_op2 <= cmd_use_imm ? cmd_imm : rs2_val;
                alu_sel <= cmd_sel;
                rd_q    <= cmd_rd;
                ill_q   <= sel_illegal;
            end
            if (state_q == EXEC) begin
                rsp_valid <= 1'b1;
                if (ill_q) begin
                    rsp_data  <= 32'd0;
                    rsp_flags <= 3'b000;
                    rsp_err   <= 1'b1;
                end else begin
                    rsp_data  <= alu_out;
                    rsp_flags <= {alu_overflow, alu_carry, alu_zero};
                    rsp_err   <= 1'b0;
                end
            end
            if ((state_q == RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    // Register file: cleared by reset, written with the ALU result at EXEC capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (wb_en) begin
            regs[rd_q] <= alu_out;
        end
    end

`ifdef ALU_STICKY_FLAGS_EN
    // Sticky {overflow, carry}: OR-accumulate on legal captures; clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_flags <= 2'b00;
        end else if (sticky_clr) begin
            sticky_flags <= 2'b00;
        end else if ((state_q == EXEC) && !ill_q) begin
            sticky_flags <= sticky_flags | {alu_overflow, alu_carry};
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_seq.sv
// Testbench for alu_issue_seq. The bench supplies the combinational ALU and
// keeps a reference register file plus an expected-response queue.
module tb_alu_issue_seq;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_sel;
  logic [3:0]  cmd_rd;
  logic [3:0]  cmd_rs1;
  logic [3:0]  cmd_rs2;
  logic [31:0] cmd_imm;
  logic        cmd_use_imm;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [3:0]  alu_sel;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic        alu_carry;
  logic        alu_overflow;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [2:0]  rsp_flags;
  logic        rsp_err;
  logic [1:0]  dbg_state;
  logic [3:0]  dbg_raddr;
  logic [31:0] dbg_rdata;
`ifdef ALU_STICKY_FLAGS_EN
  logic        sticky_clr;
  logic [1:0]  sticky_flags;
  logic [1:0]  sticky_m;
`endif

  int n_checks;
  int n_fail;

  logic [31:0] model_r [16];
  logic [35:0] exp_q [$];

  // ---------------- ALU (behavioural, bench-owned) ----------------
  // Returns {overflow, carry, zero, result}.
  function automatic logic [34:0] alu_f(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] w;
    logic [31:0] r;
    logic        c;
    logic        v;
    c = 1'b0;
    v = 1'b0;
    r = 32'd0;
    w = 33'd0;
    case (s)
      4'b0000: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[31:0];
        c = w[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'b0001: begin
        r = a - b;
        c = (a < b);
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'b0100: r = a & b;
      4'b0101: r = a | b;
      4'b0110: r = a ^ b;
      4'b1000: r = a << b[4:0];
      4'b1001: r = a >> b[4:0];
      4'b1010: r = $signed(a) >>> b[4:0];
      4'b1100: r = {31'd0, (a < b)};
      4'b1101: r = {31'd0, (a == b)};
      default: begin
        r = a ^ b ^ 32'hA5A5_0F0F;
        c = 1'b1;
        v = 1'b1;
      end
    endcase
    return {v, c, (r == 32'd0), r};
  endfunction

  function automatic bit is_legal(input logic [3:0] s);
    return s inside {4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b0110,
                     4'b1000, 4'b1001, 4'b1010, 4'b1100, 4'b1101};
  endfunction

  assign {alu_overflow, alu_carry, alu_zero, alu_out} = alu_f(alu_sel, alu_op1, alu_op2);

  alu_issue_seq #(.NREGS(16), .AW(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_sel      (cmd_sel),
    .cmd_rd       (cmd_rd),
    .cmd_rs1      (cmd_rs1),
    .cmd_rs2      (cmd_rs2),
    .cmd_imm      (cmd_imm),
    .cmd_use_imm  (cmd_use_imm),
    .alu_op1      (alu_op1),
    .alu_op2      (alu_op2),
    .alu_sel      (alu_sel),
    .alu_out      (alu_out),
    .alu_zero     (alu_zero),
    .alu_carry    (alu_carry),
    .alu_overflow (alu_overflow),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_flags    (rsp_flags),
    .rsp_err      (rsp_err),
`ifdef ALU_STICKY_FLAGS_EN
    .sticky_clr   (sticky_clr),
    .sticky_flags (sticky_flags),
`endif
    .dbg_state    (dbg_state),
    .dbg_raddr    (dbg_raddr),
    .dbg_rdata    (dbg_rdata)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model_r[i] = 32'd0;
    exp_q.delete();
`ifdef ALU_STICKY_FLAGS_EN
    sticky_m = 2'b00;
`endif
  endtask

  // ---------------- driver: one command through its full life ----------------
  task automatic issue(input logic [3:0] sel, input logic [3:0] rd, input logic [3:0] rs1,
                       input logic [3:0] rs2, input logic [31:0] imm, input logic use_imm,
                       input int delay, input bit hold_valid,
                       output logic [31:0] got_data, output logic [2:0] got_flags,
                       output logic got_err, output int waited);
    logic [31:0] a;
    logic [31:0] b;
    logic [34:0] f;
    logic        ill;
    logic [35:0] exp_v;
    got_data  = 32'd0;
    got_flags = 3'd0;
    got_err   = 1'b0;
    @(negedge clk);
    cmd_sel     = sel;
    cmd_rd      = rd;
    cmd_rs1     = rs1;
    cmd_rs2     = rs2;
    cmd_imm     = imm;
    cmd_use_imm = use_imm;
    cmd_valid   = 1'b1;
    waited      = 0;
    while (cmd_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, waited);
      cmd_valid = 1'b0;
      return;
    end
    a     = model_r[rs1];
    b     = use_imm ? imm : model_r[rs2];
    f     = alu_f(sel, a, b);
    ill   = !is_legal(sel);
    exp_v = ill ? {1'b1, 35'd0} : {1'b0, f};
    exp_q.push_back(exp_v);

    @(posedge clk);
    #1;
    if (!hold_valid) cmd_valid = 1'b0;

    // EXEC cycle: operands presented, no response yet
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL exec_idle: rsp_valid=%b cmd_ready=%b, required 0/0", rsp_valid, cmd_ready);
    end
    n_checks++;
    if ({alu_sel, alu_op1, alu_op2} !== {sel, a, b}) begin
      n_fail++;
      $display("FAIL exec_operands: sel=%h op1=%h op2=%h, required %h %h %h",
               alu_sel, alu_op1, alu_op2, sel, a, b);
    end

    // Response cycle: 2 edges after acceptance
    @(negedge clk);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rsp_latency: rsp_valid=%b, required 1", rsp_valid);
    end
    n_checks++;
    if ({rsp_err, rsp_flags, rsp_data} !== exp_v) begin
      n_fail++;
      $display("FAIL rsp_payload: err=%b flags=%b data=%h, required err=%b flags=%b data=%h",
               rsp_err, rsp_flags, rsp_data, exp_v[35], exp_v[34:32], exp_v[31:0]);
    end
    got_data  = rsp_data;
    got_flags = rsp_flags;
    got_err   = rsp_err;
    if (!ill && rd != 4'd0) model_r[rd] = f[31:0];
`ifdef ALU_STICKY_FLAGS_EN
    if (!ill) sticky_m = sticky_m | f[34:33];
    n_checks++;
    if (sticky_flags !== sticky_m) begin
      n_fail++;
      $display("FAIL sticky_track: sticky_flags=%b, required %b", sticky_flags, sticky_m);
    end
`endif

    // Backpressure: response and issue side must hold
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b1 || {rsp_err, rsp_flags, rsp_data} !== exp_v ||
          cmd_ready !== 1'b0 || {alu_sel, alu_op1, alu_op2} !== {sel, a, b}) begin
        n_fail++;
        $display("FAIL rsp_hold: valid=%b cmd_ready=%b data=%h op1=%h, required 1 0 %h %h",
                 rsp_valid, cmd_ready, rsp_data, alu_op1, exp_v[31:0], a);
      end
    end

    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rsp_release: rsp_valid=%b cmd_ready=%b, required 0/1", rsp_valid, cmd_ready);
    end
    dbg_raddr = rd;
    #1;
    n_checks++;
    if (dbg_rdata !== model_r[rd]) begin
      n_fail++;
      $display("FAIL writeback r%0d: dbg_rdata=%h, required %h", rd, dbg_rdata, model_r[rd]);
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    dbg_raddr = 4'd5;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 32'd0 || rsp_flags !== 3'd0 ||
        rsp_err !== 1'b0 || alu_op1 !== 32'd0 || alu_op2 !== 32'd0 || alu_sel !== 4'd0 ||
        dbg_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_values: cmd_ready=%b rsp_valid=%b data=%h flags=%b err=%b op1=%h op2=%h sel=%h r5=%h, required all 0",
               cmd_ready, rsp_valid, rsp_data, rsp_flags, rsp_err, alu_op1, alu_op2, alu_sel, dbg_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: cmd_ready=%b, required 1", cmd_ready);
    end
  endtask

  task automatic test_add_chain();
    logic [31:0] d;
    logic [2:0]  fl;
    logic        e;
    int          w;
    issue(4'b0000, 4'd1, 4'd0, 4'd0, 32'h10, 1'b1, 0, 1'b0, d, fl, e, w);
    issue(4'b0000, 4'd2, 4'd1, 4'd0, 32'h20, 1'b1, 0, 1'b0, d, fl, e, w);
    n_checks++;
    if (d !== 32'h30 || fl !== 3'b000 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL add_chain: data=%h flags=%b err=%b, required 00000030 000 0", d, fl, e);
    end
    dbg_raddr = 4'd2;
    #1;
    n_checks++;
    if (dbg_rdata !== 32'h30) begin
      n_fail++;
      $display("FAIL add_chain_r2: dbg_rdata=%h, required 00000030", dbg_rdata);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic [2:0]  fl;
    logic        e;
    int          w;
    issue(4'b0000, 4'd3, 4'd0, 4'd0, 32'h7FFF_FFFF, 1'b1, 0, 1'b0, d, fl, e, w);
    issue(4'b0000, 4'd4, 4'd3, 4'd0, 32'h1, 1'b1, 1, 1'b0, d, fl, e, w);
    n_checks++;
    if (d !== 32'h8000_0000 || fl !== 3'b100) begin
      n_fail++;
      $display("FAIL overflow: data=%h flags=%b, required 80000000 100", d, fl);
    end
`ifdef ALU_STICKY_FLAGS_EN
    n_checks++;
    if (sticky_flags[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL sticky_set: sticky_flags=%b, required 1x", sticky_flags);
    end
    @(negedge clk);
    sticky_clr = 1'b1;
    @(negedge clk);
    sticky_clr = 1'b0;
    sticky_m   = 2'b00;
    n_checks++;
    if (sticky_flags !== 2'b00) begin
      n_fail++;
      $display("FAIL sticky_clr: sticky_flags=%b, required 00", sticky_flags);
    end
`endif
  endtask

  task automatic test_shift_sub();
    logic [31:0] d;
    logic [2:0]  fl;
    logic        e;
    int          w;
    issue(4'b0101, 4'd5, 4'd0, 4'd0, 32'h8000_0000, 1'b1, 0, 1'b0, d, fl, e, w);
    issue(4'b1010, 4'd6, 4'd5, 4'd0, 32'h1, 1'b1, 0, 1'b0, d, fl, e, w);
    n_checks++;
    if (d !== 32'hC000_0000) begin
      n_fail++;
      $display("FAIL sra: data=%h, required c0000000", d);
    end
    issue(4'b0001, 4'd7, 4'd1, 4'd1, 32'h0, 1'b0, 0, 1'b0, d, fl, e, w);
    n_checks++;
    if (d !== 32'd0 || fl[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL sub_zero: data=%h flags=%b, required 00000000 xx1", d, fl);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] d;
    logic [2:0]  fl;
    logic        e;
    int          w;
    issue(4'b0011, 4'd8, 4'd1, 4'd2, 32'h0, 1'b0, 0, 1'b0, d, fl, e, w);
    n_checks++;
    if (e !== 1'b1 || d !== 32'd0 || fl !== 3'd0) begin
      n_fail++;
      $display("FAIL illegal: err=%b data=%h flags=%b, required 1 00000000 000", e, d, fl);
    end
    dbg_raddr = 4'd8;
    #1;
    n_checks++;
    if (dbg_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL illegal_r8: dbg_rdata=%h, required 00000000", dbg_rdata);
    end
    issue(4'b0110, 4'd9, 4'd1, 4'd2, 32'h0, 1'b0, 0, 1'b0, d, fl, e, w);
    n_checks++;
    if (e !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_clear: err=%b, required 0", e);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [2:0]  fl;
    logic        e;
    int          w;
    issue(4'b0000, 4'd10, 4'd2, 4'd1, 32'h0, 1'b0, 5, 1'b1, d, fl, e, w);
    issue(4'b0100, 4'd11, 4'd10, 4'd2, 32'h0, 1'b0, 0, 1'b0, d, fl, e, w);
    n_checks++;
    if (w !== 0) begin
      n_fail++;
      $display("FAIL b2b_accept: waited %0d cycles, required 0", w);
    end
    issue(4'b0000, 4'd0, 4'd1, 4'd0, 32'h1234, 1'b1, 0, 1'b0, d, fl, e, w);
    dbg_raddr = 4'd0;
    #1;
    n_checks++;
    if (dbg_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL r0_write: dbg_rdata=%h, required 00000000", dbg_rdata);
    end
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    cmd_sel     = 4'b0000;
    cmd_rd      = 4'd9;
    cmd_rs1     = 4'd0;
    cmd_rs2     = 4'd0;
    cmd_imm     = 32'h55;
    cmd_use_imm = 1'b1;
    cmd_valid   = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0 || alu_op1 !== 32'd0 || alu_op2 !== 32'd0) begin
      n_fail++;
      $display("FAIL midop_reset: rsp_valid=%b cmd_ready=%b op1=%h op2=%h, required 0 0 0 0",
               rsp_valid, cmd_ready, alu_op1, alu_op2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dbg_raddr = 4'd9;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || dbg_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL midop_release: cmd_ready=%b rsp_valid=%b r9=%h, required 1 0 00000000",
               cmd_ready, rsp_valid, dbg_rdata);
    end
    dbg_raddr = 4'd1;
    #1;
    n_checks++;
    if (dbg_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL midop_regs: r1=%h, required 00000000", dbg_rdata);
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [2:0]  fl;
    logic        e;
    int          w;
    for (int n = 0; n < 40; n++) begin
      issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)),
            $urandom_range(0, 3), 1'($urandom_range(0, 1)), d, fl, e, w);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_sel     = 4'd0;
    cmd_rd      = 4'd0;
    cmd_rs1     = 4'd0;
    cmd_rs2     = 4'd0;
    cmd_imm     = 32'd0;
    cmd_use_imm = 1'b0;
    rsp_ready   = 1'b0;
    dbg_raddr   = 4'd0;
`ifdef ALU_STICKY_FLAGS_EN
    sticky_clr  = 1'b0;
`endif
    test_reset();
    test_add_chain();
    test_overflow();
    test_shift_sub();
    test_illegal();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
